// File: rtl/sig_sched_pkg.sv
// Shared types for the signature-cell scheduler: FSM state encoding and id width helper.
package sig_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    OUT
  } state_e;

  // Requester index width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sig_rr_arb.sv
// Combinational requester arbiter; round-robin from last+1, or fixed lowest-index
// priority when SIG_SCHED_FIXED_PRIO_EN is defined (the last pointer then disappears).
module sig_rr_arb
  import sig_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef SIG_SCHED_FIXED_PRIO_EN
  input  logic [IDW-1:0]  last,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
`ifdef SIG_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      j = i;
      if (!found && req[j[IDW-1:0]]) begin
        found             = 1'b1;
        gnt[j[IDW-1:0]]   = 1'b1;
        idx               = j[IDW-1:0];
      end
    end
`else
    // Walk NREQ slots starting just after the previous winner, wrapping.
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(last) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j[IDW-1:0]]) begin
        found             = 1'b1;
        gnt[j[IDW-1:0]]   = 1'b1;
        idx               = j[IDW-1:0];
      end
    end
`endif
  end

endmodule

// File: rtl/sig_sched.sv
// Shares one signature keystream cell among NREQ requesters: load, clock WIDTH bits,
// return the collected word over valid/ready. Arbitration mode: SIG_SCHED_FIXED_PRIO_EN.
module sig_sched
  import sig_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  localparam int IDW  = id_w(NREQ),
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic             sig_ld,
  output logic             sig_en,
  input  logic             sig_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDW-1:0]   out_id,
  output logic [NREQ-1:0]  done,
  output logic             busy
);

  state_e           state, state_n;
  logic [CW-1:0]    cnt;
  logic             cap;
  logic [WIDTH-1:0] shreg;
  logic [IDW-1:0]   id_q;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
`ifndef SIG_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]   last;
`endif

  sig_rr_arb #(.NREQ(NREQ)) u_arb (
    .req  (req),
`ifndef SIG_SCHED_FIXED_PRIO_EN
    .last (last),
`endif
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= 1'b0;
      shreg <= '0;
      id_q  <= '0;
`ifndef SIG_SCHED_FIXED_PRIO_EN
      last  <= IDW'(NREQ - 1);
`endif
    end else begin
      state <= state_n;
      // The cell registers q, so each bit lands one cycle after its enable.
      cap   <= (state == RUN);
      case (state)
        IDLE: if (|gnt) begin
          id_q <= gnt_idx;
`ifndef SIG_SCHED_FIXED_PRIO_EN
          last <= gnt_idx;
`endif
        end
        LOAD: begin
          cnt   <= '0;
          shreg <= '0;
        end
        RUN:     cnt <= cnt + 1'b1;
        default: ;
      endcase
      if (cap) shreg <= {shreg[WIDTH-2:0], sig_q};
    end
  end

  always_comb begin
    state_n   = state;
    sig_ld    = 1'b0;
    sig_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|gnt) state_n = LOAD;
      end
      LOAD: begin
        sig_ld  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        sig_en = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_n = DRAIN;
      end
      DRAIN: state_n = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done[id_q] = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_data = shreg;
  assign out_id   = id_q;

endmodule

// File: doc/sig_sched.md
# sig_sched

Sequencer and arbiter that shares one signature keystream cell between `NREQ` requesters. On each grant it reloads the cell, clocks it for `WIDTH` enable cycles, and collects the serial parity bits into a `WIDTH`-bit word. It then returns the word, tagged with the requester id, over a valid/ready handshake. It sits between the cipher's requesting units and the single signature cell, and drives that cell's `ld` and `en` inputs.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `WIDTH`, default 8: bits collected per grant, range 2..32.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input NREQ: level request, one bit per requester.
- `sig_ld` output 1: load strobe to the signature cell.
- `sig_en` output 1: enable to the signature cell.
- `sig_q` input 1: serial output of the signature cell (registered in the cell).
- `out_valid` output 1: the collected word is available.
- `out_ready` input 1: the consumer accepts the word.
- `out_data` output WIDTH: collected word; the first captured bit is the MSB.
- `out_id` output max(1,$clog2(NREQ)): index of the requester that was served.
- `done` output NREQ: one-hot pulse on the handshake cycle (`out_valid && out_ready`).
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, OUT.
- **IDLE:** if any `req` bit is high, the arbiter picks a winner, latches it in `out_id`, and moves to LOAD. Otherwise it stays in IDLE.
- **LOAD:** `sig_ld`=1 for exactly one cycle. Clear the shift register and the bit counter. Go to RUN.
- **RUN:** `sig_en`=1 for exactly `WIDTH` consecutive cycles, counted by a `$clog2(WIDTH+1)`-bit counter. Go to DRAIN after the `WIDTH`-th cycle.
- **DRAIN:** `sig_en`=0 for one cycle, which captures the last bit. Go to OUT.
- **OUT:** hold `out_valid`=1 with `out_data` and `out_id` stable until `out_ready`=1. On that cycle pulse `done[out_id]` and return to IDLE.
- **Capture:** `cap` is `sig_en` delayed by one register. When `cap`=1, shift in `sig_q`: shreg <= {shreg[WIDTH-2:0], sig_q}. Exactly `WIDTH` bits are captured per grant.
- **Arbitration:** round-robin. A `last` pointer records the most recent winner. The search starts at `last+1` and wraps modulo `NREQ`. `last` updates only when a winner is latched in IDLE.
- `req` is sampled only in IDLE. A requester that drops `req` mid-grant still receives its word.
- A requester that keeps `req` high after its `done` is eligible again. Round-robin ordering still lets the other requesters go first.
- A request arriving on the same cycle as a handshake is seen in the following IDLE cycle.
- `sig_ld` and `sig_en` are never high in the same cycle.

## Timing
- Reset values: state=IDLE, `sig_ld`=0, `sig_en`=0, `out_valid`=0, `out_data`=0, `out_id`=0, `done`=0, `busy`=0, `last`=NREQ-1, so requester 0 is favoured first.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values. No `done` pulse is issued and the partial word is discarded.
- Latency: `req` is seen in IDLE at cycle 0. LOAD is cycle 1, RUN is cycles 2..WIDTH+1, DRAIN is cycle WIDTH+2, and `out_valid` first rises in cycle WIDTH+3.
- Minimum grant-to-grant period is WIDTH+4 cycles with `out_ready` held at 1.
- Outputs are registers or decodes of registered state only, with no combinational path from inputs. The one exception is `done`, which is the registered state ANDed with `out_ready`.

## Configuration
- `SIG_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and the `last` pointer is removed.
  - Undefined (default): round-robin as described under Operation.

## Structure
- Shared package `sig_sched_pkg`: state enum (IDLE, LOAD, RUN, DRAIN, OUT) and the id width function `max(1,$clog2(n))`.
- Sub-module `sig_rr_arb`:
  - Purely combinational grant logic.
  - Inputs: `req`, `last`. Outputs: one-hot `gnt`, encoded `idx`.
  - Hosts the `SIG_SCHED_FIXED_PRIO_EN` switch.
- The bench supplies a signature cell model: counter reset/load value 0x55, q <= parity(counter), counter increments on `en`.

## Test plan
- **Single request:** WIDTH=8, NREQ=2, `req`=01, `out_ready`=1.
  - `out_valid` rises at cycle 11.
  - `out_data`=0x32, `out_id`=0, `done`=01 on that cycle.
- **Round-robin:** `req`=11 held constantly.
  - Served ids are 0,1,0,1.
  - Every word is 0x32, because of the reload.
  - Grant period is 12 cycles.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in OUT.
  - `out_data` and `out_id` stay stable and `done` stays 0.
  - `done` pulses exactly once when `out_ready` rises.
- **Reset mid-RUN:** assert `reset` at RUN cycle 4.
  - Next cycle is IDLE with all outputs at reset values.
  - A re-issued `req`=10 yields `out_id`=1, `out_data`=0x32.
- **Width boundary:** WIDTH=2.
  - `out_data`=2'b00 after 2 enables.
  - `sig_en` is high for exactly 2 cycles.
- **Fixed priority:** `SIG_SCHED_FIXED_PRIO_EN` defined, `req`=11 held.
  - Id 0 is served every time; id 1 is never served.
